grad_xy_stream: RTL and testbench



---
 rtl/grad_xy_stream.sv | 168 ++++++++++++++++
 tb/tb_grad_xy_stream.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/grad_xy_stream.sv
// grad_xy_stream
//   Accepts one (SIDE+2)x(SIDE+2) pixel window per in_val/in_rdy handshake.
//   Streams the central-difference gradients (Ix, Iy) over the SIDE x SIDE
//   interior, one pair per cycle in raster order, with out_val/out_rdy
//   backpressure. A new window can be taken during the final handshake of
//   the current one, so consecutive windows stream with no bubble.
//
// Parameters
//   SIDE  interior side; N = SIDE*SIDE pairs per window
//   W     unsigned pixel width
//
// Ports
//   clk       clock, rising edge
//   reset_n   asynchronous active-low reset
//   in_val    window valid
//   in_rdy    window accepted when in_val & in_rdy
//   in_win    flattened window, pixel (r,c) at [W*(r*(SIDE+2)+c) +: W]
//   out_val   gradient pair valid
//   out_rdy   consumer ready
//   out_ix    signed Ix = p(i+1,j+2) - p(i+1,j)
//   out_iy    signed Iy = p(i+2,j+1) - p(i,j+1)
//   out_idx   raster index i*SIDE+j
//   out_last  high with the pair at index N-1
//   out_mag   |Ix|+|Iy| saturated (only when GRAD_XY_MAG_EN is defined)
//
// Optional feature macro: GRAD_XY_MAG_EN
//
// state  | meaning
// IDLE   | no window held, in_rdy=1, out_val=0
// STREAM | presenting pair idx of the held window, out_val=1

module grad_xy_stream #(
  parameter int SIDE = 3,
  parameter int W    = 8,
  localparam int N    = SIDE * SIDE,
  localparam int IDXW = (N > 1) ? $clog2(N) : 1,
  localparam int WINW = W * (SIDE + 2) * (SIDE + 2)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_val,
  output logic            in_rdy,
  input  logic [WINW-1:0] in_win,
  output logic            out_val,
  input  logic            out_rdy,
  output logic [W:0]      out_ix,
  output logic [W:0]      out_iy,
`ifdef GRAD_XY_MAG_EN
  output logic [W:0]      out_mag,
`endif
  output logic [IDXW-1:0] out_idx,
  output logic            out_last
);

  localparam int RW = (SIDE > 1) ? $clog2(SIDE) : 1;
  localparam int PW = $clog2(SIDE + 2);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [WINW-1:0] win_q;
  logic [IDXW-1:0] idx_q, idx_d;
  // Row/column kept alongside idx so pixel selection needs no divider.
  logic [RW-1:0]   row_q, row_d, col_q, col_d;
  logic            capture;
  logic            last_pos;

  assign last_pos = (idx_q == IDXW'(N - 1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    row_d   = row_q;
    col_d   = col_q;
    capture = 1'b0;
    in_rdy  = 1'b0;
    out_val = 1'b0;
    case (state_q)
      IDLE: begin
        in_rdy = 1'b1;
        if (in_val) begin
          capture = 1'b1;
          state_d = STREAM;
          idx_d   = '0;
          row_d   = '0;
          col_d   = '0;
        end
      end
      STREAM: begin
        out_val = 1'b1;
        // Next window may enter only on the final handshake of this one.
        in_rdy  = last_pos & out_rdy;
        if (out_rdy) begin
          if (!last_pos) begin
            idx_d = idx_q + IDXW'(1);
            if (col_q == RW'(SIDE - 1)) begin
              col_d = '0;
              row_d = row_q + RW'(1);
            end else begin
              col_d = col_q + RW'(1);
            end
          end else if (in_val) begin
            capture = 1'b1;
            idx_d   = '0;
            row_d   = '0;
            col_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      win_q   <= '0;
      idx_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      row_q   <= row_d;
      col_q   <= col_d;
      if (capture) win_q <= in_win;
    end
  end

  logic [W-1:0] pix [SIDE+2][SIDE+2];

  for (genvar r = 0; r < SIDE + 2; r++) begin : g_row
    for (genvar c = 0; c < SIDE + 2; c++) begin : g_col
      assign pix[r][c] = win_q[W*(r*(SIDE+2)+c) +: W];
    end
  end

  logic [PW-1:0] r_top, r_mid, r_bot, c_lft, c_mid, c_rgt;

  assign r_top = PW'(row_q);
  assign r_mid = r_top + PW'(1);
  assign r_bot = r_top + PW'(2);
  assign c_lft = PW'(col_q);
  assign c_mid = c_lft + PW'(1);
  assign c_rgt = c_lft + PW'(2);

  // Zero-extended W+1 bit subtraction cannot overflow.
  assign out_ix   = {1'b0, pix[r_mid][c_rgt]} - {1'b0, pix[r_mid][c_lft]};
  assign out_iy   = {1'b0, pix[r_bot][c_mid]} - {1'b0, pix[r_top][c_mid]};
  assign out_idx  = idx_q;
  assign out_last = out_val & last_pos;

`ifdef GRAD_XY_MAG_EN
  logic [W:0]   abs_ix, abs_iy;
  logic [W+1:0] mag_sum;

  assign abs_ix  = out_ix[W] ? (~out_ix + (W+1)'(1)) : out_ix;
  assign abs_iy  = out_iy[W] ? (~out_iy + (W+1)'(1)) : out_iy;
  assign mag_sum = {1'b0, abs_ix} + {1'b0, abs_iy};
  assign out_mag = mag_sum[W+1] ? '1 : mag_sum[W:0];
`endif

endmodule

// File: tb/tb_grad_xy_stream.sv
module tb_grad_xy_stream;

  localparam int SIDE = 3;
  localparam int W    = 8;
  localparam int P    = SIDE + 2;
  localparam int N    = SIDE * SIDE;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           in_val;
  logic           in_rdy;
  logic [W*P*P-1:0] in_win;
  logic           out_val;
  logic           out_rdy;
  logic [W:0]     out_ix;
  logic [W:0]     out_iy;
  logic [3:0]     out_idx;
  logic           out_last;
`ifdef GRAD_XY_MAG_EN
  logic [W:0]     out_mag;
`endif

  grad_xy_stream #(.SIDE(SIDE), .W(W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_val   (in_val),
    .in_rdy   (in_rdy),
    .in_win   (in_win),
    .out_val  (out_val),
    .out_rdy  (out_rdy),
    .out_ix   (out_ix),
    .out_iy   (out_iy),
`ifdef GRAD_XY_MAG_EN
    .out_mag  (out_mag),
`endif
    .out_idx  (out_idx),
    .out_last (out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ix;
    int iy;
    int idx;
    int last;
    int mag;
  } exp_t;

  exp_t q[$];
  int   pix [P][P];
  int   ncmp = 0;
  int   nbad = 0;
  int   hs   = 0;

  task automatic chk(input string tag, input int got, input int exp);
    ncmp++;
    if (got != exp) begin
      nbad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // kind: 0 horizontal ramp, 1 vertical ramp, 2 left column 255, 3 random
  task automatic load(input int kind);
    for (int r = 0; r < P; r++)
      for (int c = 0; c < P; c++) begin
        case (kind)
          0:       pix[r][c] = 10 * c;
          1:       pix[r][c] = 5 * r;
          2:       pix[r][c] = (c == 0) ? 255 : 0;
          default: pix[r][c] = int'($urandom_range(0, 255));
        endcase
        in_win[W*(r*P+c) +: W] = pix[r][c][W-1:0];
      end
  endtask

  task automatic push_window();
    exp_t e;
    int ax, ay;
    for (int i = 0; i < SIDE; i++)
      for (int j = 0; j < SIDE; j++) begin
        e.ix   = pix[i+1][j+2] - pix[i+1][j];
        e.iy   = pix[i+2][j+1] - pix[i][j+1];
        e.idx  = i * SIDE + j;
        e.last = (e.idx == N - 1) ? 1 : 0;
        ax     = (e.ix < 0) ? -e.ix : e.ix;
        ay     = (e.iy < 0) ? -e.iy : e.iy;
        e.mag  = (ax + ay > 511) ? 511 : ax + ay;
        q.push_back(e);
      end
  endtask

  // Called at posedge+1; samples at the negedge and advances the model
  // by the handshakes that the coming posedge will perform.
  task automatic step();
    bit exp_val, exp_in_rdy, fire_out, fire_in;
    @(negedge clk);
    exp_val    = (q.size() != 0);
    exp_in_rdy = (q.size() == 0) || (q.size() == 1 && out_rdy);
    chk("out_val", int'(out_val), int'(exp_val));
    chk("in_rdy", int'(in_rdy), int'(exp_in_rdy));
    if (exp_val) begin
      chk("out_ix", int'($signed(out_ix)), q[0].ix);
      chk("out_iy", int'($signed(out_iy)), q[0].iy);
      chk("out_idx", int'(out_idx), q[0].idx);
      chk("out_last", int'(out_last), q[0].last);
`ifdef GRAD_XY_MAG_EN
      chk("out_mag", int'(out_mag), q[0].mag);
`endif
    end else begin
      chk("out_last_idle", int'(out_last), 0);
    end
    fire_out = exp_val && out_rdy;
    fire_in  = in_val && exp_in_rdy;
    if (fire_out) begin
      void'(q.pop_front());
      hs++;
    end
    if (fire_in) push_window();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int lim);
    int k = 0;
    while (q.size() != 0 && k < lim) begin
      step();
      k++;
    end
    chk("drain_left", q.size(), 0);
  endtask

  task automatic run_to_idx(input int target);
    int k = 0;
    while (q.size() != 0 && q[0].idx != target && k < 40) begin
      step();
      k++;
    end
    chk("reach_idx", (q.size() != 0) ? q[0].idx : -1, target);
  endtask

  initial begin
    reset_n = 1'b0;
    in_val  = 1'b1;
    out_rdy = 1'b1;
    load(0);
    #1;
    chk("rst_out_val", int'(out_val), 0);
    chk("rst_in_rdy", int'(in_rdy), 1);
    chk("rst_out_idx", int'(out_idx), 0);
    chk("rst_out_ix", int'(out_ix), 0);
    chk("rst_out_iy", int'(out_iy), 0);
    chk("rst_out_last", int'(out_last), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Horizontal ramp, in_val held high: captured at first edge, then ignored.
    hs = 0;
    step();
    load(3);
    for (int k = 0; k < 4; k++) step();
    in_val = 1'b0;
    drain(20);
    chk("hramp_hs", hs, N);

    // Vertical ramp and left-edge case.
    for (int kind = 1; kind <= 2; kind++) begin
      load(kind);
      in_val = 1'b1;
      step();
      in_val = 1'b0;
      drain(20);
    end

    // Backpressure at idx 4 for three cycles.
    hs = 0;
    load(3);
    in_val = 1'b1;
    step();
    in_val = 1'b0;
    run_to_idx(4);
    out_rdy = 1'b0;
    for (int k = 0; k < 3; k++) step();
    out_rdy = 1'b1;
    drain(20);
    chk("bp_hs", hs, N);

    // Back-to-back: window B offered during the idx 8 handshake.
    load(3);
    in_val = 1'b1;
    step();
    in_val = 1'b0;
    run_to_idx(8);
    load(3);
    in_val = 1'b1;
    step();
    in_val = 1'b0;
    chk("b2b_queued", q.size(), N);
    drain(20);

    // Reset mid-stream at idx 3.
    load(3);
    in_val = 1'b1;
    step();
    in_val = 1'b0;
    run_to_idx(3);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_out_val", int'(out_val), 0);
    chk("mid_rst_in_rdy", int'(in_rdy), 1);
    chk("mid_rst_out_idx", int'(out_idx), 0);
    q.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    hs = 0;
    load(3);
    in_val = 1'b1;
    step();
    in_val = 1'b0;
    drain(20);
    chk("post_rst_hs", hs, N);

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      load(3);
      in_val  = ($urandom_range(0, 1) == 1);
      out_rdy = ($urandom_range(0, 3) != 0);
      step();
    end
    in_val  = 1'b0;
    out_rdy = 1'b1;
    drain(40);

    $display("test done: total=%0d bad=%0d", ncmp, nbad);
    $finish;
  end

endmodule
